frame_reader: RTL and testbench

- Reads a captured camera frame back out of the 32-bit frame SRAM and streams it as bytes to a byte-wide consumer (UART/USB bridge) over a valid/ready handshake.
- Consumes the word layout written by the capture path:
  - 32-bit words at addresses 0..last_addr.
  - First-captured byte in bits [7:0], last in [31:24].
- Started by a kick from the host-side controller; reports completion with read_done.

---
 rtl/frame_reader_pkg.sv | 33 +++
 rtl/frame_reader_fifo.sv | 45 ++++
 rtl/frame_reader.sv | 177 +++++++++++++++++
 tb/tb_frame_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_reader_pkg.sv
// Shared camera definitions: SRAM geometry, frame markers, reader state encoding.
// Optional frame header is enabled by defining FRAME_HEADER_EN.
package frame_reader_pkg;
  localparam int AW = 18;
  localparam int DW = 32;

  localparam logic [AW-1:0] EMPTY_FRAME = 18'h3ffff;
  localparam logic [7:0]    HDR_B0      = 8'hA5;
  localparam logic [7:0]    HDR_B1      = 8'h5A;
  localparam logic [2:0]    HDR_LEN     = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } rd_state_e;

  typedef struct packed {
    logic          re;
    logic [AW-1:0] addr;
  } sram_req_t;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [AW-1:0] wt);
    case (idx)
      3'd0:    hdr_byte = HDR_B0;
      3'd1:    hdr_byte = HDR_B1;
      3'd2:    hdr_byte = {6'b0, wt[17:16]};
      3'd3:    hdr_byte = wt[15:8];
      default: hdr_byte = wt[7:0];
    endcase
  endfunction
endpackage

// File: rtl/frame_reader_fifo.sv
// Show-ahead synchronous word FIFO buffering prefetched SRAM words.
module frame_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/frame_reader.sv
// Streams a captured frame out of the 32-bit frame SRAM as bytes over valid/ready.
// Define FRAME_HEADER_EN to prefix each readout with a 5-byte header.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          read_kick,
  input  logic [AW-1:0] last_addr,
  output logic          busy,
  output logic          read_done,
  output logic          m_RE,
  output logic [AW-1:0] m_Addr,
  input  logic [DW-1:0] m_RD,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [19:0]   byte_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e           state_q, state_d;
  logic [2:0]          kick_sync_q;
  logic                start;
  logic [AW-1:0]       word_total_q, rd_cnt_q;
  sram_req_t           req_q;
  logic [RD_LATENCY:1] vld_q;
  logic [RD_LATENCY:0] vld_pipe;
  logic [7:0]          outstanding;
  logic                issue;

  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_cnt;
  logic [DW-1:0]       fifo_rdata;

  logic                out_valid_q, is_pay_q;
  logic [7:0]          out_data_q;
  logic [DW-1:0]       wd_q;
  logic [1:0]          lane_q;
  logic [19:0]         byte_cnt_q;
  logic [2:0]          hdr_idx;
  logic                hdr_pend, accept, slot_free, adv_lane, load_hdr, pop, drained;

  // Stages 0..1 are the 2-flop synchroniser, stage 2 holds the previous level for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) kick_sync_q <= '0;
    else          kick_sync_q <= {kick_sync_q[1:0], read_kick};
  end

  assign start = kick_sync_q[1] & ~kick_sync_q[2] & (state_q == IDLE || state_q == DONE);

  // Bit 0 is the read presented this cycle; bit RD_LATENCY marks m_RD as valid.
  assign vld_pipe = {vld_q, req_q.re};

  always_comb begin
    outstanding = 8'(fifo_cnt);
    for (int i = 0; i <= RD_LATENCY; i++) outstanding = outstanding + 8'(vld_pipe[i]);
  end

  assign issue = (state_q == FETCH) && (rd_cnt_q != word_total_q) && !fifo_full &&
                 (outstanding < 8'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_total_q <= '0;
      rd_cnt_q     <= '0;
      req_q        <= '0;
      vld_q        <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_pipe[RD_LATENCY-1:0];
      req_q.re <= issue;
      if (start) begin
        word_total_q <= last_addr + 1'b1;
        rd_cnt_q     <= '0;
      end else if (issue) begin
        req_q.addr <= rd_cnt_q;
        rd_cnt_q   <= rd_cnt_q + 1'b1;
      end
    end
  end

  // An empty frame still passes through DRAIN so read_done visibly drops for a cycle.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    read_done = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        read_done = (state_q == DONE);
        if (start) state_d = (last_addr == EMPTY_FRAME) ? DRAIN : FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (rd_cnt_q == word_total_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drained) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  frame_reader_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (vld_pipe[RD_LATENCY]),
    .wdata_i (m_RD),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

`ifdef FRAME_HEADER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      hdr_idx <= HDR_LEN;
    else if (start)    hdr_idx <= '0;
    else if (load_hdr) hdr_idx <= hdr_idx + 3'd1;
  end
`else
  assign hdr_idx = HDR_LEN;
`endif

  assign hdr_pend  = (hdr_idx != HDR_LEN);
  assign accept    = out_valid_q & out_ready;
  assign slot_free = ~out_valid_q | accept;
  assign adv_lane  = accept & is_pay_q & (lane_q != 2'd3);
  assign load_hdr  = slot_free & ~adv_lane & hdr_pend;
  assign pop       = slot_free & ~adv_lane & ~hdr_pend & ~fifo_empty;
  assign drained   = ~|vld_pipe & fifo_empty & ~out_valid_q & ~hdr_pend;

  // Output byte register: header bytes take priority, then lanes of the held word,
  // and a fresh word is popped on the lane-3 acceptance for gapless streaming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wd_q        <= '0;
      lane_q      <= '0;
      is_pay_q    <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      if (start)       byte_cnt_q <= '0;
      else if (accept) byte_cnt_q <= byte_cnt_q + 20'd1;

      if (adv_lane) begin
        lane_q     <= lane_q + 2'd1;
        out_data_q <= wd_q[{lane_q + 2'd1, 3'b000} +: 8];
      end else if (load_hdr) begin
        out_valid_q <= 1'b1;
        out_data_q  <= hdr_byte(hdr_idx, word_total_q);
        is_pay_q    <= 1'b0;
      end else if (pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fifo_rdata[7:0];
        wd_q        <= fifo_rdata;
        lane_q      <= '0;
        is_pay_q    <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_RE      = req_q.re;
  assign m_Addr    = req_q.addr;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign byte_cnt  = byte_cnt_q;
endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: RD_LATENCY=1 and RD_LATENCY=3 instances run in lockstep
// against SRAM models, with per-instance expected-byte queues.
module tb_frame_reader;
  localparam int N = 2;
`ifdef FRAME_HEADER_EN
  localparam int HDR = 5;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0, reset_n = 1'b1, read_kick = 1'b0, out_ready = 1'b1;
  logic [17:0] last_addr = '0;
  logic        busy [N], read_done [N], m_RE [N], out_valid [N];
  logic [17:0] m_Addr [N];
  logic [31:0] m_RD [N];
  logic [7:0]  out_data [N];
  logic [19:0] byte_cnt [N];

  always #5 clk = ~clk;

  frame_reader #(.RD_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .read_kick(read_kick), .last_addr(last_addr),
    .busy(busy[0]), .read_done(read_done[0]), .m_RE(m_RE[0]), .m_Addr(m_Addr[0]),
    .m_RD(m_RD[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .out_ready(out_ready), .byte_cnt(byte_cnt[0]));

  frame_reader #(.RD_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .read_kick(read_kick), .last_addr(last_addr),
    .busy(busy[1]), .read_done(read_done[1]), .m_RE(m_RE[1]), .m_Addr(m_Addr[1]),
    .m_RD(m_RD[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .out_ready(out_ready), .byte_cnt(byte_cnt[1]));

  function automatic logic [7:0] wbyte(input int i, input int j);
    logic [7:0] b;
    b = 8'(4 * i + j);
    b[1:0] = b[1:0] ^ 2'(i >> 6);
    return b;
  endfunction

  logic [31:0] mem [256];
  logic [31:0] d1a, d3a, d3b, d3c;
  always @(posedge clk) begin
    d1a <= m_RE[0] ? mem[m_Addr[0][7:0]] : 32'hDEADBEEF;
    d3a <= m_RE[1] ? mem[m_Addr[1][7:0]] : 32'hDEADBEEF;
    d3b <= d3a;
    d3c <= d3b;
  end
  assign m_RD[0] = d1a;
  assign m_RD[1] = d3c;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int nvec = 0, nerr = 0, cyc = 0;
  int re_cnt [N], acc_cnt [N], first_addr [N], max_out [N];
  int first_acc, last_acc;
  bit stall [N];
  logic [7:0] hold [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      for (int d = 0; d < N; d++) stall[d] = 0;
    end else begin
      for (int d = 0; d < N; d++) begin
        int o, pay, have;
        logic [7:0] e;
        if (m_RE[d]) begin
          if (re_cnt[d] == 0) first_addr[d] = int'(m_Addr[d]);
          re_cnt[d]++;
        end
        if (stall[d]) begin
          chk("hold_valid", 32'(out_valid[d]), 1);
          chk("hold_data", 32'(out_data[d]), 32'(hold[d]));
        end
        stall[d] = out_valid[d] && !out_ready;
        hold[d]  = out_data[d];
        if (out_valid[d] && out_ready) begin
          if (d == 0) begin
            if (acc_cnt[0] == 0) first_acc = cyc;
            last_acc = cyc;
            have = exp0.size();
            e = (have != 0) ? exp0.pop_front() : 8'h00;
          end else begin
            have = exp1.size();
            e = (have != 0) ? exp1.pop_front() : 8'h00;
          end
          acc_cnt[d]++;
          chk("byte_expected", 32'(have != 0), 1);
          if (have != 0) chk("byte_value", 32'(out_data[d]), 32'(e));
        end
        pay = (acc_cnt[d] > HDR) ? acc_cnt[d] - HDR : 0;
        o = re_cnt[d] - (pay + 3) / 4;
        if (o > max_out[d]) max_out[d] = o;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [17:0] la);
    logic [17:0] wt;
    wt = la + 18'd1;
`ifdef FRAME_HEADER_EN
    begin
      logic [7:0] h [5];
      h[0] = 8'hA5; h[1] = 8'h5A; h[2] = {6'b0, wt[17:16]}; h[3] = wt[15:8]; h[4] = wt[7:0];
      for (int k = 0; k < 5; k++) begin exp0.push_back(h[k]); exp1.push_back(h[k]); end
    end
`endif
    for (int i = 0; i < int'(wt); i++)
      for (int j = 0; j < 4; j++) begin
        exp0.push_back(wbyte(i, j));
        exp1.push_back(wbyte(i, j));
      end
    for (int d = 0; d < N; d++) begin
      re_cnt[d] = 0; acc_cnt[d] = 0; first_addr[d] = -1; max_out[d] = 0;
    end
    last_addr = la;
    read_kick = 1'b1;
    step();
    read_kick = 1'b0;
  endtask

  task automatic wait_done(input int mode, output int lat);
    int t, t0;
    bit seen, got;
    t = 0; t0 = 0; seen = 0; got = 0; lat = -1;
    while (t < 20000) begin
      if (mode != 0) out_ready = 1'($urandom_range(0, 1));
      step();
      t++;
      if (!seen && busy[0]) begin
        seen = 1; t0 = t;
        chk("done_cleared", 32'(read_done[0]), 0);
      end
      if (seen && !got && read_done[0]) begin got = 1; lat = t - t0; end
      if (got && read_done[1] && !busy[1] && !out_valid[1]) break;
    end
    chk("done_in_time", 32'(t < 20000), 1);
    out_ready = 1'b1;
    step();
  endtask

  task automatic end_checks(input int words);
    for (int d = 0; d < N; d++) begin
      chk("byte_cnt", 32'(byte_cnt[d]), 32'(4 * words + HDR));
      chk("re_count", 32'(re_cnt[d]), 32'(words));
      chk("read_done", 32'(read_done[d]), 1);
      chk("busy_low", 32'(busy[d]), 0);
      if (words > 0) chk("first_addr", 32'(first_addr[d]), 0);
    end
    chk("queue0_drained", 32'(exp0.size()), 0);
    chk("queue1_drained", 32'(exp1.size()), 0);
  endtask

  task automatic reset_chk(input string tag);
    for (int d = 0; d < N; d++) begin
      chk({tag, "_ctl"}, 32'({busy[d], read_done[d], m_RE[d], out_valid[d]}), 0);
      chk({tag, "_addr"}, 32'(m_Addr[d]), 0);
      chk({tag, "_data_cnt"}, 32'({out_data[d], byte_cnt[d]}), 0);
    end
  endtask

  initial begin
    int lat, t;
    for (int i = 0; i < 256; i++) mem[i] = {wbyte(i, 3), wbyte(i, 2), wbyte(i, 1), wbyte(i, 0)};
    #2 reset_n = 1'b0;
    repeat (3) step();
    reset_chk("reset");
    reset_n = 1'b1;
    repeat (2) step();

    // four words at full rate
    run_frame(18'h00003);
    wait_done(0, lat);
    end_checks(4);
    chk("contiguous", 32'(last_acc - first_acc), 32'(16 + HDR - 1));

    // empty frame
    run_frame(18'h3ffff);
    wait_done(0, lat);
    chk("empty_latency", 32'(lat >= 0 && lat <= 4), 1);
    end_checks(0);

    // 256 words with a stuttering consumer
    run_frame(18'h000FF);
    wait_done(1, lat);
    end_checks(256);
    for (int d = 0; d < N; d++) chk("max_outstanding", 32'(max_out[d] <= 5), 1);

    // second kick mid-readout is ignored
    run_frame(18'h0003F);
    t = 0;
    while (byte_cnt[0] < 20'(40 + HDR) && t < 5000) begin step(); t++; end
    chk("reach_word10", 32'(t < 5000), 1);
    read_kick = 1'b1; step(); read_kick = 1'b0;
    wait_done(0, lat);
    end_checks(64);
    for (int d = 0; d < N; d++) chk("max_outstanding_fast", 32'(max_out[d] <= 5), 1);

    // restart after DONE begins again at address 0
    run_frame(18'h00003);
    wait_done(0, lat);
    end_checks(4);

    // two-word frame
    run_frame(18'h00001);
    wait_done(0, lat);
    end_checks(2);

    // asynchronous reset mid-stream
    run_frame(18'h000FF);
    t = 0;
    while (byte_cnt[0] < 20'd10 && t < 2000) begin step(); t++; end
    chk("reach_mid_stream", 32'(t < 2000), 1);
    #2 reset_n = 1'b0;
    #1 reset_chk("midreset");
    exp0.delete();
    exp1.delete();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    reset_chk("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
